// File: rtl/program_loader_pkg.sv
// Shared parameters for the program loader.
//   loader_state_t : loader FSM state encoding
//   sz_word        : memory access size code for a 32-bit word
//   mem_start      : default byte address of the first loaded word
//   mem_depth      : default size in bytes of the writable window
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ASSEMBLE,
        WRITE,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [1:0]  sz_word   = 2'b10;
    localparam logic [31:0] mem_start = 32'h8002_0000;
    localparam logic [31:0] mem_depth = 32'h0001_0000;

endpackage

// File: rtl/program_loader_word_packer.sv
// Big-endian byte-to-word packer.
//   clk     : rising-edge clock
//   reset   : asynchronous, active-low
//   byte_in : next byte
//   valid   : byte_in is accepted this cycle
//   clear   : discard the partial word and restart at byte 0
//   word    : packed word, already including byte_in when valid is high
//   count   : number of bytes held (wraps to 0 after the 4th byte)
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        valid,
    input  logic        clear,
    output logic [31:0] word,
    output logic [1:0]  count
);

    logic [31:0] word_q;
    logic [1:0]  count_q;
    logic [31:0] merged;

    // Byte 0 lands in bits 31:24, byte 3 in bits 7:0.
    always_comb begin
        merged = word_q;
        case (count_q)
            2'd0:    merged[31:24] = byte_in;
            2'd1:    merged[23:16] = byte_in;
            2'd2:    merged[15:8]  = byte_in;
            default: merged[7:0]   = byte_in;
        endcase
    end

    // The merged view lets the loader capture a finished word on the
    // same edge that accepts its final byte.
    assign word  = valid ? merged : word_q;
    assign count = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q  <= '0;
            count_q <= '0;
        end else if (clear) begin
            word_q  <= '0;
            count_q <= '0;
        end else if (valid) begin
            word_q  <= merged;
            count_q <= count_q + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams a big-endian byte image into memory as 32-bit word writes,
// holding the processor in reset until the whole image is written.
//   clk, reset          : clock, asynchronous active-low reset
//   start               : pulse that begins (or restarts) a load
//   in_data/valid/last  : byte stream; in_ready is the accept handshake
//   mem_*               : memory write port (one-cycle mem_enable strobes)
//   cpu_reset           : active-high processor reset, released in DONE
//   done / error        : image written / image overflowed the window
//   word_count          : words written in the current load (saturating)
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [31:0] base_addr = mem_start,
    parameter logic [31:0] depth     = mem_depth
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [1:0]  mem_access_sz,
    output logic        mem_rd_wr,
    output logic        mem_enable,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    localparam logic [32:0] window_end = {1'b0, base_addr} + {1'b0, depth};

    loader_state_t state;
    logic [31:0]   addr;
    logic          last_seen;
    logic          accept;
    logic          restart;
    logic          pk_clear;
    logic [31:0]   pk_word;
    logic [1:0]    pk_count;

    assign mem_access_sz = sz_word;
    assign accept   = in_valid && in_ready;
    assign restart  = start && (state == IDLE || state == DONE || state == ERROR);
    assign pk_clear = restart || (state == WRITE);

    word_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .byte_in (in_data),
        .valid   (accept),
        .clear   (pk_clear),
        .word    (pk_word),
        .count   (pk_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr       <= base_addr;
            last_seen  <= 1'b0;
            word_count <= '0;
            in_ready   <= 1'b0;
            mem_enable <= 1'b0;
            mem_rd_wr  <= 1'b1;
            mem_din    <= '0;
            mem_addr   <= base_addr;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else if (restart) begin
            state      <= ASSEMBLE;
            addr       <= base_addr;
            last_seen  <= 1'b0;
            word_count <= '0;
            in_ready   <= 1'b1;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                ASSEMBLE: begin
                    if (accept && (pk_count == 2'd3 || in_last)) begin
                        last_seen <= in_last;
                        in_ready  <= 1'b0;
                        if ({1'b0, addr} >= window_end) begin
                            state <= ERROR;
                            error <= 1'b1;
                        end else begin
                            state      <= WRITE;
                            mem_enable <= 1'b1;
                            mem_rd_wr  <= 1'b0;
                            mem_addr   <= addr;
                            mem_din    <= pk_word;
                        end
                    end
                end
                WRITE: begin
                    mem_enable <= 1'b0;
                    mem_rd_wr  <= 1'b1;
                    mem_din    <= '0;
                    addr       <= addr + 32'd4;
                    if (word_count != 16'hFFFF) begin
                        word_count <= word_count + 16'd1;
                    end
                    if (last_seen) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        state    <= ASSEMBLE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h8002_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [1:0]  mem_access_sz;
    logic        mem_rd_wr;
    logic        mem_enable;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    program_loader #(.base_addr(BASE), .depth(32'd8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
        .mem_access_sz (mem_access_sz),
        .mem_rd_wr     (mem_rd_wr),
        .mem_enable    (mem_enable),
        .cpu_reset     (cpu_reset),
        .done          (done),
        .error         (error),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset && mem_enable) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(exp_q.size()), 32'd1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", mem_addr, e.addr);
                check("write_data", mem_din, e.data);
                check("write_rd_wr", {31'b0, mem_rd_wr}, 32'd0);
                check("write_in_ready", {31'b0, in_ready}, 32'd0);
            end
        end else if (reset) begin
            check("idle_mem_din", mem_din, 32'd0);
            check("idle_rd_wr", {31'b0, mem_rd_wr}, 32'd1);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit ok;
        ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_image(input logic [7:0] img[$], input bit gap);
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], i == img.size() - 1);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done || error) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_end_timeout"}, {31'b0, done | error}, 32'd1);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [7:0]  img[$];
        int unsigned p0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_mem_enable", {31'b0, mem_enable}, 32'd0);
        check("rst_rd_wr", {31'b0, mem_rd_wr}, 32'd1);
        check("rst_mem_din", mem_din, 32'd0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        check("rst_word_count", {16'b0, word_count}, 32'd0);
        check("access_sz", {30'b0, mem_access_sz}, 32'd2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single full word.
        p0 = pulses;
        push(BASE, 32'h1234_5678);
        pulse_start();
        img = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_image(img, 1'b0);
        wait_end("s1");
        check("s1_word_count", {16'b0, word_count}, 32'd1);
        check("s1_done", {31'b0, done}, 32'd1);
        check("s1_cpu_reset", {31'b0, cpu_reset}, 32'd0);
        check("s1_pulses", pulses - p0, 32'd1);

        // Two full words.
        p0 = pulses;
        push(BASE, 32'h0001_0203);
        push(BASE + 32'd4, 32'h0405_0607);
        pulse_start();
        img = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        send_image(img, 1'b0);
        wait_end("s2");
        check("s2_word_count", {16'b0, word_count}, 32'd2);
        check("s2_done", {31'b0, done}, 32'd1);
        check("s2_pulses", pulses - p0, 32'd2);

        // Partial final word is zero padded.
        p0 = pulses;
        push(BASE, 32'hAABB_CCDD);
        push(BASE + 32'd4, 32'hEE00_0000);
        pulse_start();
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_image(img, 1'b0);
        wait_end("s3");
        check("s3_word_count", {16'b0, word_count}, 32'd2);
        check("s3_pulses", pulses - p0, 32'd2);

        // Overflow of the 8-byte window.
        p0 = pulses;
        push(BASE, 32'h1011_1213);
        push(BASE + 32'd4, 32'h1415_1617);
        pulse_start();
        img = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B};
        send_image(img, 1'b0);
        wait_end("s4");
        repeat (3) @(negedge clk);
        check("s4_error", {31'b0, error}, 32'd1);
        check("s4_done", {31'b0, done}, 32'd0);
        check("s4_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("s4_in_ready", {31'b0, in_ready}, 32'd0);
        check("s4_pulses", pulses - p0, 32'd2);
        check("s4_word_count", {16'b0, word_count}, 32'd2);
        @(posedge clk);
        #1;

        // Same image as the two-word load, with bubbles between bytes.
        p0 = pulses;
        push(BASE, 32'h0001_0203);
        push(BASE + 32'd4, 32'h0405_0607);
        pulse_start();
        img = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        send_image(img, 1'b1);
        wait_end("s5");
        check("s5_done", {31'b0, done}, 32'd1);
        check("s5_error", {31'b0, error}, 32'd0);
        check("s5_pulses", pulses - p0, 32'd2);

        // Reset in the middle of a load.
        p0 = pulses;
        pulse_start();
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("s6_rst_mem_enable", {31'b0, mem_enable}, 32'd0);
        check("s6_rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("s6_rst_word_count", {16'b0, word_count}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("s6_idle_in_ready", {31'b0, in_ready}, 32'd0);
        check("s6_no_write", pulses - p0, 32'd0);
        @(posedge clk);
        #1;
        push(BASE, 32'h9ABC_DEF0);
        pulse_start();
        img = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        send_image(img, 1'b0);
        wait_end("s6");
        check("s6_done", {31'b0, done}, 32'd1);
        check("s6_word_count", {16'b0, word_count}, 32'd1);
        check("s6_pulses", pulses - p0, 32'd1);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL provide parameter base_addr, default mem_start, byte address of the first word written.
REQ-002 The block SHALL provide parameter depth, default mem_depth, size in bytes of the writable window starting at base_addr.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low
- start  input  1  one-cycle pulse that begins a load
- in_data  input  8  next program byte, big-endian order
- in_valid  input  1  in_data valid
- in_last  input  1  in_data is the final byte of the image
- in_ready  output  1  loader accepts in_data this cycle
- mem_addr  output  32  memory byte address
- mem_din  output  32  memory write data
- mem_access_sz  output  2  constant sz_word
- mem_rd_wr  output  1  1=read, 0=write
- mem_enable  output  1  memory access strobe
- cpu_reset  output  1  active-high reset to the processor
- done  output  1  image fully written
- error  output  1  image exceeded window
- word_count  output  16  words written in the current load

Function
REQ-005 The FSM SHALL have states IDLE, ASSEMBLE, WRITE, DONE, ERROR.
REQ-006 IDLE: in_ready=0, mem_enable=0; start -> ASSEMBLE with address=base_addr, byte counter=0, word_count=0, done=0, error=0.
REQ-007 ASSEMBLE: in_ready=1; a byte is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-008 Accepted bytes SHALL be packed big-endian: byte 0 -> bits 31:24, byte 3 -> bits 7:0.
REQ-009 On acceptance of the 4th byte, or of any byte with in_last=1, the FSM SHALL go to WRITE; unfilled low bytes of a partial word are zero.
REQ-010 If the pending write address is >= base_addr+depth, the FSM SHALL go to ERROR instead of WRITE, and no memory write occurs.
REQ-011 WRITE lasts exactly one cycle: mem_enable=1, mem_rd_wr=0, mem_addr=current address, mem_din=packed word, in_ready=0.
REQ-012 On leaving WRITE: address += 4, word_count += 1, byte counter=0; next state is DONE if in_last was seen, else ASSEMBLE.
REQ-013 In every state except WRITE: mem_enable=0, mem_rd_wr=1, mem_din=0.
REQ-014 cpu_reset SHALL be 1 in all states except DONE, and 0 in DONE from the first DONE cycle.
REQ-015 DONE: done=1, in_ready=0; ERROR: error=1, in_ready=0; both hold until start.
REQ-016 start in DONE or ERROR SHALL restart as in REQ-006; start in ASSEMBLE or WRITE is ignored.
REQ-017 in_last on the 4th byte SHALL produce exactly one write, not an extra empty word.
REQ-018 word_count SHALL saturate at 16'hFFFF.

Reset
REQ-019 While reset=0, the block SHALL force state=IDLE, address=base_addr, word_count=0, mem_enable=0, mem_rd_wr=1, mem_din=0, mem_addr=base_addr, in_ready=0, cpu_reset=1, done=0, error=0.
REQ-020 Reset asserted mid-load SHALL abort with no further writes; the partially accepted word is discarded.

Structure
REQ-021 The loader_state_t enum and the sz_word, mem_start and mem_depth constants SHALL reside in the shared params package.
REQ-022 Byte packing SHALL be a sub-module word_packer (byte in, valid, clear, 32-bit word out, 2-bit count out).

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Bytes 12 34 56 78 with in_last on 78 -> one write of 0x12345678 at 0x80020000; word_count=1; done=1; cpu_reset=0.
- 8 bytes 00..07 with in_last on 07 -> writes 0x00010203 @0x80020000 and 0x04050607 @0x80020004; exactly 2 mem_enable pulses.
- 5 bytes AA BB CC DD EE with in_last on EE -> second write is 0xEE000000 @0x80020004.
- depth=8, 12 bytes -> two writes, then error=1, no third write, cpu_reset stays 1.
- in_valid toggled every other cycle -> identical memory image; in_ready=0 during every WRITE cycle.
- reset driven low after 2 bytes, released, then start -> mem_enable stays 0 until the new load; first write at 0x80020000.
